pixel_ram_responder: RTL and testbench
======================================

Name: pixel_ram_responder

Overview:
- Memory-side responder for the LED matrix pixel read interface. It accepts the controller's byte read requests (address plus request strobe) into a request FIFO and returns bytes from an on-chip single-port pixel RAM, in order, with a data-valid strobe.
- Applies early backpressure through fifo_full.
- Also exposes a host write port used to load frames into the same RAM.
- Sits between the frame source and the matrix controller.

Parameters:
- ADDRESS_WIDTH, 25, width of request and write addresses.
- MEM_DEPTH, 320, RAM bytes (10 pixels × 16 lines × 2 halves); valid addresses are 0..MEM_DEPTH-1.
- REQ_FIFO_DEPTH, 8, request FIFO entries; power of two, ≥4.
- FULL_MARGIN, 2, free-entry slack at which fifo_full asserts; covers the requester's one-cycle registered reaction.
- WRITE_STARVE_LIMIT, 4, consecutive read grants with a host write pending before one write is forced.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_address  in  ADDRESS_WIDTH  read byte address.
- req_valid  in  1  read request strobe; one request per high cycle.
- fifo_full  out  1  backpressure to the requester.
- rsp_data  out  8  returned byte, packed RGB 3-3-2.
- rsp_valid  out  1  one-cycle pulse per response; there is no backpressure.
- wr_en  in  1  host write request.
- wr_address  in  ADDRESS_WIDTH  host write address.
- wr_data  in  8  host write byte.
- wr_ready  out  1  high in a cycle where wr_en is consumed (write is granted).
- req_overflow  out  1  sticky: a request was dropped.
- addr_error  out  1  sticky: a read or write address was ≥ MEM_DEPTH.
- err_clear  in  1  clears both sticky flags.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset values: fifo_full=0, rsp_valid=0, rsp_data=0, wr_ready=0, req_overflow=0, addr_error=0. Reset also clears FIFO pointers and count, the starvation counter and the response pipeline. RAM contents are not cleared.
- Reset mid-operation: queued and in-flight requests are discarded, and no rsp_valid appears after reset asserts.
- Push:
  - When req_valid=1 and (count<REQ_FIFO_DEPTH, or count==REQ_FIFO_DEPTH with a pop in the same cycle), the request is written to the FIFO.
  - Otherwise the request is dropped and req_overflow is set. It is never silently lost.
- fifo_full: registered; equals (count_next ≥ REQ_FIFO_DEPTH − FULL_MARGIN).
- Arbiter: single-port RAM, one access per cycle. Two states:
  - ARB_READ:
    - If the FIFO is non-empty, pop the head and read the RAM.
    - If wr_en is also high, increment the starve counter. When the counter reaches WRITE_STARVE_LIMIT, go to ARB_WRITE for the next cycle.
    - If the FIFO is empty and wr_en=1, grant the write this cycle (wr_ready=1) with no state change.
  - ARB_WRITE:
    - Grant the pending write (wr_ready=1), clear the starve counter, return to ARB_READ.
    - If wr_en dropped, just return.
  - The starve counter clears whenever wr_en=0.
- wr_ready: combinational from state, FIFO empty and wr_en. The host holds wr_en, wr_address and wr_data until wr_ready=1.
- Read latency:
  - A request pushed in cycle N can pop at earliest N+1; the RAM is read in that cycle and rsp_valid/rsp_data are registered at N+2.
  - From an empty FIFO with no write contention, latency is 2 cycles.
  - Sustained throughput is 1 byte/cycle.
- Ordering: responses are strictly in request order. A write granted before a read's pop is visible to that read; a write granted after it is not.
- Out-of-range read: address ≥ MEM_DEPTH returns rsp_data=0x00 with a normal rsp_valid, and sets addr_error.
- Out-of-range write: accepted (wr_ready=1), the RAM is unchanged, and addr_error is set.
- Address truncation: addresses are compared at full ADDRESS_WIDTH; no truncation aliasing.
- err_clear: clears both flags that cycle. If a new error occurs in the same cycle, the set wins.

Test Plan:
- Load then stream: host writes 0x00..0x13 into addresses 0..19, then 20 back-to-back reads of addresses 0..19 → first rsp_valid 2 cycles after the first req_valid, then 20 consecutive pulses with rsp_data 0x00..0x13 in order.
- Backpressure: burst requests with no pops possible (ARB_WRITE forced) → fifo_full rises when count reaches 6. A requester reacting one cycle late pushes at most 2 more, and req_overflow stays 0.
- Overflow: drive req_valid continuously ignoring fifo_full while writes stall pops → the 9th unpopped request is dropped, req_overflow=1; err_clear → 0.
- Write starvation: wr_en held high under continuous reads → wr_ready pulses once after every 4 read grants, and responses stay in order.
- Bounds: read address 320 → rsp_data=0x00, addr_error=1. Write to 500 → wr_ready=1, RAM unchanged (read back address 0 is unaffected).
- Reset mid-stream: assert reset with 5 requests queued → no further rsp_valid, fifo_full=0. After release, a read of address 3 returns its pre-reset contents.

Source files
------------

// File: rtl/pixel_ram_responder.sv
// pixel_ram_responder
//   Memory-side responder for the LED matrix pixel read interface. Read
//   requests are queued in a request FIFO and served in order from a
//   single-port pixel RAM. A host write port loads frames into the same RAM.
//   The RAM does one access per cycle, so reads and host writes are
//   arbitrated. A read that waits too long is not possible, but a host write
//   can be delayed. After WRITE_STARVE_LIMIT read grants with a write pending,
//   one write is forced.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous active-high reset
//   req_address   read byte address
//   req_valid     read request strobe, one request per high cycle
//   fifo_full     registered early backpressure (FULL_MARGIN entries of slack)
//   rsp_data      returned byte (RGB 3-3-2), held between responses
//   rsp_valid     one-cycle pulse per response, no backpressure
//   wr_en         host write request, held until wr_ready
//   wr_address    host write address
//   wr_data       host write byte
//   wr_ready      combinational write grant
//   req_overflow  sticky: a read request was dropped
//   addr_error    sticky: a read or write address was >= MEM_DEPTH
//   err_clear     clears both sticky flags (a same-cycle new error wins)
module pixel_ram_responder #(
   parameter int ADDRESS_WIDTH      = 25,
   parameter int MEM_DEPTH          = 320,
   parameter int REQ_FIFO_DEPTH     = 8,
   parameter int FULL_MARGIN        = 2,
   parameter int WRITE_STARVE_LIMIT = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ADDRESS_WIDTH-1:0] req_address,
   input  logic                     req_valid,
   output logic                     fifo_full,
   output logic [7:0]               rsp_data,
   output logic                     rsp_valid,
   input  logic                     wr_en,
   input  logic [ADDRESS_WIDTH-1:0] wr_address,
   input  logic [7:0]               wr_data,
   output logic                     wr_ready,
   output logic                     req_overflow,
   output logic                     addr_error,
   input  logic                     err_clear
);

   localparam int PTR_W  = $clog2(REQ_FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int MEM_AW = $clog2(MEM_DEPTH);
   localparam int STV_W  = $clog2(WRITE_STARVE_LIMIT + 1);

   localparam logic [ADDRESS_WIDTH-1:0] MEM_LIMIT   = ADDRESS_WIDTH'(MEM_DEPTH);
   localparam logic [CNT_W-1:0]         FIFO_CAP    = CNT_W'(REQ_FIFO_DEPTH);
   localparam logic [CNT_W-1:0]         FULL_LEVEL  = CNT_W'(REQ_FIFO_DEPTH - FULL_MARGIN);
   localparam logic [STV_W-1:0]         STARVE_LAST = STV_W'(WRITE_STARVE_LIMIT - 1);

   typedef enum logic {
      ARB_READ,
      ARB_WRITE
   } arb_state_t;

   arb_state_t state, state_next;
   logic [STV_W-1:0] starve_cnt, starve_next;

   logic [ADDRESS_WIDTH-1:0] fifo_mem [REQ_FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr, rd_ptr;
   logic [CNT_W-1:0]         count, count_next;
   logic                     fifo_empty;
   logic                     pop, push;

   logic [7:0]               mem [MEM_DEPTH];
   logic [ADDRESS_WIDTH-1:0] head_addr;
   logic                     head_in_range, wr_in_range;
   logic                     read_err, write_err;

   assign fifo_empty    = (count == '0);
   assign head_addr     = fifo_mem[rd_ptr];
   // Range checks use the full address width so high address bits never alias
   // into the RAM.
   assign head_in_range = (head_addr < MEM_LIMIT);
   assign wr_in_range   = (wr_address < MEM_LIMIT);

   // ---------------------------------------------------------------- arbiter
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ARB_READ;
         starve_cnt <= '0;
      end else begin
         state      <= state_next;
         starve_cnt <= starve_next;
      end
   end

   always_comb begin
      state_next  = state;
      starve_next = starve_cnt;
      case (state)
         ARB_READ: begin
            if (!wr_en || wr_ready) begin
               starve_next = '0;
            end else if (pop) begin
               // The read granted here is the LIMIT-th one with a write waiting.
               if (starve_cnt == STARVE_LAST) begin
                  starve_next = '0;
                  state_next  = ARB_WRITE;
               end else begin
                  starve_next = starve_cnt + 1'b1;
               end
            end
         end
         ARB_WRITE: begin
            starve_next = '0;
            state_next  = ARB_READ;
         end
         default: state_next = ARB_READ;
      endcase
   end

   // Grants are suppressed during reset so no RAM access or pop happens then.
   always_comb begin
      pop      = 1'b0;
      wr_ready = 1'b0;
      if (!reset) begin
         case (state)
            ARB_READ: begin
               pop      = !fifo_empty;
               wr_ready = fifo_empty && wr_en;
            end
            ARB_WRITE: wr_ready = wr_en;
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------ request FIFO
   // A full FIFO still accepts a request when the head leaves in the same cycle.
   assign push       = !reset && req_valid && ((count != FIFO_CAP) || pop);
   assign count_next = count + CNT_W'(push) - CNT_W'(pop);
   assign read_err   = pop && !head_in_range;
   assign write_err  = wr_ready && !wr_in_range;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= req_address;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         fifo_full    <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_data     <= '0;
         req_overflow <= 1'b0;
         addr_error   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr   <= rd_ptr + 1'b1;
            rsp_data <= head_in_range ? mem[head_addr[MEM_AW-1:0]] : 8'h00;
         end
         count        <= count_next;
         fifo_full    <= (count_next >= FULL_LEVEL);
         rsp_valid    <= pop;
         req_overflow <= (req_valid && !push) || (req_overflow && !err_clear);
         addr_error   <= read_err || write_err || (addr_error && !err_clear);
      end
   end

   // ---------------------------------------------------------------- pixel RAM
   // Contents survive reset; out-of-range writes are granted but discarded.
   always_ff @(posedge clk) begin
      if (wr_ready && wr_in_range) begin
         mem[wr_address[MEM_AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: tb/tb_pixel_ram_responder.sv
// Testbench for pixel_ram_responder. Directed scenarios followed by a random
// phase; every cycle is compared against a queue/array reference model.
module tb_pixel_ram_responder;

   localparam int AW     = 25;
   localparam int DEPTH  = 320;
   localparam int FD     = 8;
   localparam int MARGIN = 2;
   localparam int LIMIT  = 4;

   logic          clk         = 1'b0;
   logic          reset       = 1'b1;
   logic [AW-1:0] req_address = '0;
   logic          req_valid   = 1'b0;
   logic          fifo_full;
   logic [7:0]    rsp_data;
   logic          rsp_valid;
   logic          wr_en       = 1'b0;
   logic [AW-1:0] wr_address  = '0;
   logic [7:0]    wr_data     = '0;
   logic          wr_ready;
   logic          req_overflow;
   logic          addr_error;
   logic          err_clear   = 1'b0;

   always #5 clk = ~clk;

   pixel_ram_responder #(
      .ADDRESS_WIDTH(AW),
      .MEM_DEPTH(DEPTH),
      .REQ_FIFO_DEPTH(FD),
      .FULL_MARGIN(MARGIN),
      .WRITE_STARVE_LIMIT(LIMIT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req_address(req_address),
      .req_valid(req_valid),
      .fifo_full(fifo_full),
      .rsp_data(rsp_data),
      .rsp_valid(rsp_valid),
      .wr_en(wr_en),
      .wr_address(wr_address),
      .wr_data(wr_data),
      .wr_ready(wr_ready),
      .req_overflow(req_overflow),
      .addr_error(addr_error),
      .err_clear(err_clear)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // Reference model: RAM image, queue of pending read addresses, and a
   // count of read grants that went by while a host write was waiting.
   logic [7:0]  ref_mem [DEPTH];
   int unsigned ref_q [$];
   int          starve = 0;
   bit          owed   = 0;
   bit          grant  = 0;
   bit          e_valid = 0, e_full = 0, e_ovf = 0, e_aerr = 0;
   logic [7:0]  e_data = '0;
   logic        last_wr_ready = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock cycle: inputs are already driven; predict, check the grant,
   // clock, then check registered outputs.
   task automatic step();
      int unsigned sz;
      int unsigned a;
      bit          pop_m, set_ovf, set_aerr;
      #1;
      if (reset) begin
         grant = 0;
         ref_q.delete();
         starve = 0; owed = 0;
         e_valid = 0; e_data = '0; e_full = 0; e_ovf = 0; e_aerr = 0;
      end else begin
         sz       = ref_q.size();
         grant    = wr_en && (owed || sz == 0);
         pop_m    = !owed && sz > 0;
         set_ovf  = 0;
         set_aerr = 0;
         e_valid  = pop_m;
         if (pop_m) begin
            a = ref_q.pop_front();
            if (a < DEPTH) e_data = ref_mem[a];
            else begin
               e_data   = 8'h00;
               set_aerr = 1;
            end
         end
         if (grant) begin
            if (wr_address < DEPTH) ref_mem[wr_address] = wr_data;
            else set_aerr = 1;
         end
         if (owed) begin
            owed = 0; starve = 0;
         end else if (!wr_en || grant) begin
            starve = 0;
         end else if (pop_m) begin
            starve++;
            if (starve == LIMIT) begin
               owed = 1; starve = 0;
            end
         end
         if (req_valid) begin
            if (ref_q.size() < FD) ref_q.push_back(int'(req_address));
            else set_ovf = 1;
         end
         e_full = (ref_q.size() >= FD - MARGIN);
         e_ovf  = set_ovf || (e_ovf && !err_clear);
         e_aerr = set_aerr || (e_aerr && !err_clear);
      end
      last_wr_ready = wr_ready;
      check("wr_ready", 32'(wr_ready), 32'(grant));
      @(posedge clk);
      #1;
      cyc++;
      check("rsp_valid", 32'(rsp_valid), 32'(e_valid));
      check("rsp_data", 32'(rsp_data), 32'(e_data));
      check("fifo_full", 32'(fifo_full), 32'(e_full));
      check("req_overflow", 32'(req_overflow), 32'(e_ovf));
      check("addr_error", 32'(addr_error), 32'(e_aerr));
   endtask

   function automatic logic [AW-1:0] rand_addr();
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 8)       return AW'($urandom_range(0, DEPTH - 1));
      else if (r == 8) return AW'($urandom_range(DEPTH, 1023));
      else             return AW'($urandom);
   endfunction

   logic [7:0] got [$];
   int         first_k, last_k, rv_seen;
   int         grants [$];
   logic       prev_full;
   bit         saw_full;

   initial begin
      // Reset
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;

      // Preload whole RAM so every later read has a known value
      for (int a = 0; a < DEPTH; a++) begin
         wr_en = 1'b1; wr_address = AW'(a); wr_data = 8'($urandom);
         step();
      end

      // Load then stream
      for (int a = 0; a < 20; a++) begin
         wr_en = 1'b1; wr_address = AW'(a); wr_data = 8'(a);
         step();
      end
      wr_en = 1'b0;
      got.delete(); first_k = -1; last_k = -1;
      for (int k = 0; k < 24; k++) begin
         req_valid   = (k < 20);
         req_address = AW'(k);
         step();
         if (rsp_valid) begin
            if (first_k < 0) first_k = k;
            last_k = k;
            got.push_back(rsp_data);
         end
      end
      req_valid = 1'b0;
      check("stream_first_latency", 32'(first_k), 32'd1);
      check("stream_span", 32'(last_k - first_k), 32'd19);
      check("stream_count", 32'(got.size()), 32'd20);
      for (int k = 0; k < got.size(); k++) check("stream_data", 32'(got[k]), 32'(k));

      // Bounds: read 320, aliasing probes, write 500
      req_valid = 1'b1; req_address = AW'(320);
      step();
      req_valid = 1'b0;
      step();
      check("oob_read_valid", 32'(rsp_valid), 32'd1);
      check("oob_read_data", 32'(rsp_data), 32'h00);
      check("oob_read_err", 32'(addr_error), 32'd1);
      err_clear = 1'b1;
      step();
      err_clear = 1'b0;
      check("err_clear", 32'(addr_error), 32'd0);
      req_valid = 1'b1; req_address = AW'(515);
      step();
      req_address = 25'h100_0003;
      step();
      req_valid = 1'b0;
      check("alias515_data", 32'(rsp_data), 32'h00);
      step();
      check("alias_hi_data", 32'(rsp_data), 32'h00);
      err_clear = 1'b1;
      step();
      err_clear = 1'b0;
      wr_en = 1'b1; wr_address = AW'(500); wr_data = 8'hAA;
      step();
      wr_en = 1'b0;
      check("oob_write_ready", 32'(last_wr_ready), 32'd1);
      check("oob_write_err", 32'(addr_error), 32'd1);
      req_valid = 1'b1; req_address = AW'(0);
      step();
      req_valid = 1'b0;
      step();
      check("addr0_intact", 32'(rsp_data), 32'h00);

      // Write starvation: grants every LIMIT+1 cycles under continuous reads
      grants.delete();
      for (int k = 0; k < 26; k++) begin
         req_valid = 1'b1; req_address = AW'($urandom_range(0, 19));
         if (k == 0 || last_wr_ready) begin
            wr_en = 1'b1; wr_address = AW'($urandom_range(200, 299)); wr_data = 8'($urandom);
         end
         step();
         if (last_wr_ready) grants.push_back(k);
      end
      req_valid = 1'b0; wr_en = 1'b0;
      check("starve_grants", 32'(grants.size()), 32'd6);
      for (int i = 0; i < grants.size(); i++)
         check("starve_spacing", 32'(grants[i]), 32'(i * (LIMIT + 1)));
      repeat (10) step();

      // Backpressure with a requester that reacts one cycle late
      prev_full = 1'b0; saw_full = 0;
      for (int k = 0; k < 80; k++) begin
         req_valid   = !prev_full;
         req_address = AW'($urandom_range(0, DEPTH - 1));
         prev_full   = fifo_full;
         if (fifo_full) saw_full = 1;
         if (k == 0 || last_wr_ready) begin
            wr_en = 1'b1; wr_address = AW'($urandom_range(200, 299)); wr_data = 8'($urandom);
         end
         step();
      end
      check("bp_saw_full", 32'(saw_full), 32'd1);
      check("bp_no_overflow", 32'(req_overflow), 32'd0);

      // Overflow: ignore fifo_full while writes steal cycles
      for (int k = 0; k < 60; k++) begin
         req_valid   = 1'b1;
         req_address = AW'($urandom_range(0, DEPTH - 1));
         if (last_wr_ready) begin
            wr_en = 1'b1; wr_address = AW'($urandom_range(200, 299)); wr_data = 8'($urandom);
         end
         step();
      end
      check("ovf_set", 32'(req_overflow), 32'd1);
      req_valid = 1'b0; wr_en = 1'b0; err_clear = 1'b1;
      step();
      err_clear = 1'b0;
      check("ovf_cleared", 32'(req_overflow), 32'd0);
      repeat (12) step();

      // Reset mid-stream with requests queued
      for (int k = 0; k < 100 && ref_q.size() < 5; k++) begin
         req_valid = 1'b1; req_address = AW'($urandom_range(0, 19));
         if (k == 0 || last_wr_ready) begin
            wr_en = 1'b1; wr_address = AW'($urandom_range(200, 299)); wr_data = 8'($urandom);
         end
         step();
      end
      check("queued_before_reset", 32'(ref_q.size() >= 5), 32'd1);
      req_valid = 1'b0; wr_en = 1'b0; reset = 1'b1;
      rv_seen = 0;
      step(); rv_seen += int'(rsp_valid);
      step(); rv_seen += int'(rsp_valid);
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         rv_seen += int'(rsp_valid);
      end
      check("reset_no_rsp", 32'(rv_seen), 32'd0);
      check("reset_fifo_full", 32'(fifo_full), 32'd0);
      req_valid = 1'b1; req_address = AW'(3);
      step();
      req_valid = 1'b0;
      step();
      check("post_reset_valid", 32'(rsp_valid), 32'd1);
      check("post_reset_addr3", 32'(rsp_data), 32'h03);

      // Random traffic
      for (int k = 0; k < 1500; k++) begin
         reset       = ($urandom_range(0, 299) == 0);
         req_valid   = ($urandom_range(0, 3) != 0);
         req_address = rand_addr();
         if (!wr_en || last_wr_ready) begin
            wr_en      = ($urandom_range(0, 2) != 0);
            wr_address = rand_addr();
            wr_data    = 8'($urandom);
         end
         err_clear = ($urandom_range(0, 19) == 0);
         step();
      end
      reset = 1'b0; req_valid = 1'b0; wr_en = 1'b0; err_clear = 1'b0;
      repeat (12) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
